// File: rtl/booth_mul_seq.sv
// Sequential signed radix-2 Booth multiplier: one Booth step per clock, 2W-bit product streamed high byte then low byte.
// Optional BOOTH_MUL_ADD_REM_EN adds a serially loaded remainder to the product (dividend reconstruction).
module booth_mul_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_bus,
  input  logic         begin_mul,
  output logic         fin,
  output logic         busy,
  output logic [W-1:0] out_bus
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_Q   = 3'd1,
    ITER   = 3'd2,
    OUT_HI = 3'd3,
    OUT_LO = 3'd4
`ifdef BOOTH_MUL_ADD_REM_EN
    ,
    LD_R   = 3'd5,
    ADD_R  = 3'd6
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   m_q, m_d;
  logic           qm1_q, qm1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           fin_q, fin_d;
  logic           busy_q, busy_d;
  logic [W-1:0]   out_q, out_d;
  logic [W:0]     sum;
`ifdef BOOTH_MUL_ADD_REM_EN
  logic [W-1:0]   r_q, r_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      out_q   <= '0;
`ifdef BOOTH_MUL_ADD_REM_EN
      r_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
`ifdef BOOTH_MUL_ADD_REM_EN
      r_q     <= r_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    sum     = '0;
`ifdef BOOTH_MUL_ADD_REM_EN
    r_d     = r_q;
`endif

    case (state_q)
      IDLE: begin
        if (begin_mul) begin
          m_d     = in_bus;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(W);
          state_d = LD_Q;
        end
      end
      LD_Q: begin
        q_d = in_bus;
`ifdef BOOTH_MUL_ADD_REM_EN
        state_d = LD_R;
`else
        state_d = ITER;
`endif
      end
`ifdef BOOTH_MUL_ADD_REM_EN
      LD_R: begin
        r_d     = in_bus;
        state_d = ITER;
      end
`endif
      ITER: begin
        // One extra accumulator bit keeps the true sign when A+/-M overflows W bits
        case ({q_q[0], qm1_q})
          2'b01:   sum = {a_q[W-1], a_q} + {m_q[W-1], m_q};
          2'b10:   sum = {a_q[W-1], a_q} - {m_q[W-1], m_q};
          default: sum = {a_q[W-1], a_q};
        endcase
        a_d   = sum[W:1];
        q_d   = {sum[0], q_q[W-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
`ifdef BOOTH_MUL_ADD_REM_EN
          state_d = ADD_R;
`else
          state_d = OUT_HI;
`endif
        end
      end
`ifdef BOOTH_MUL_ADD_REM_EN
      ADD_R: begin
        {a_d, q_d} = {a_q, q_q} + {{W{r_q[W-1]}}, r_q};
        state_d    = OUT_HI;
      end
`endif
      OUT_HI:  state_d = OUT_LO;
      OUT_LO:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so fin/out_bus line up exactly with OUT_HI/OUT_LO
  always_comb begin
    fin_d  = (state_d == OUT_HI) || (state_d == OUT_LO);
    busy_d = (state_d != IDLE);
    out_d  = '0;
    if (state_d == OUT_HI) begin
      out_d = a_d;
    end else if (state_d == OUT_LO) begin
      out_d = q_d;
    end
  end

  assign fin     = fin_q;
  assign busy    = busy_q;
  assign out_bus = out_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: vector table, randomized ops against an arithmetic model, abort-by-reset sequence.
module tb_booth_mul_seq;

  localparam int W = 8;
`ifdef BOOTH_MUL_ADD_REM_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif
  localparam int LAT = REM_EN ? W + 4 : W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_bus;
  logic         begin_mul;
  logic         fin;
  logic         busy;
  logic [W-1:0] out_bus;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] m;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           noise;
  } vec_t;

  vec_t vecs[$];

  booth_mul_seq #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_bus   (in_bus),
    .begin_mul(begin_mul),
    .fin      (fin),
    .busy     (busy),
    .out_bus  (out_bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q,
                                           input logic [W-1:0] r);
    longint p;
    p = longint'($signed(m)) * longint'($signed(q));
    if (REM_EN) p = p + longint'($signed(r));
    return p[2*W-1:0];
  endfunction

  task automatic add_vec(input logic [W-1:0] m, input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic [W-1:0] hi, input logic [W-1:0] lo, input bit noise);
    vec_t v;
    v.m = m; v.q = q; v.r = r; v.hi = hi; v.lo = lo; v.noise = noise;
    vecs.push_back(v);
  endtask

  // Starts in the current cycle, checks every cycle up to and including the first idle cycle after OUT_LO
  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic [W-1:0] hi, input logic [W-1:0] lo, input bit noise,
                       input string tag);
    logic [W-1:0] exp_out;
    begin_mul = 1'b1;
    in_bus    = m;
    step();
    for (int c = 1; c <= LAT + 1; c++) begin
      exp_out = (c == LAT) ? hi : (c == LAT + 1) ? lo : '0;
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'd1);
      chk($sformatf("%s fin c%0d", tag, c), 32'(fin), 32'(c >= LAT));
      chk($sformatf("%s out_bus c%0d", tag, c), 32'(out_bus), 32'(exp_out));
      begin_mul = 1'b0;
      in_bus    = W'($urandom);
      if (c == 1) in_bus = q;
      if (c == 2) in_bus = r;
      if (noise && (c == 3 || c == LAT + 1)) begin_mul = 1'b1;
      step();
    end
    chk($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s idle fin", tag), 32'(fin), 32'd0);
    chk($sformatf("%s idle out_bus", tag), 32'(out_bus), 32'd0);
    begin_mul = 1'b0;
  endtask

  initial begin
    logic [2*W-1:0] p;
    logic [W-1:0]   rm, rq, rr;

    rst       = 1'b1;
    begin_mul = 1'b0;
    in_bus    = '0;
    step();
    step();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset fin", 32'(fin), 32'd0);
    chk("reset out_bus", 32'(out_bus), 32'd0);
    rst = 1'b0;
    step();

    add_vec(8'h03, 8'h05, 8'h00, 8'h00, 8'h0F, 1'b1);
    add_vec(8'hF9, 8'h03, 8'h00, 8'hFF, 8'hEB, 1'b0);
    add_vec(8'h7F, 8'h80, 8'h00, 8'hC0, 8'h80, 1'b0);
    add_vec(8'h80, 8'h80, 8'h00, 8'h40, 8'h00, 1'b0);
    add_vec(8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
    add_vec(8'h7F, 8'h7F, 8'h00, 8'h3F, 8'h01, 1'b0);
    add_vec(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 1'b1);
    add_vec(8'h80, 8'h7F, 8'h00, 8'hC0, 8'h80, 1'b0);
`ifdef BOOTH_MUL_ADD_REM_EN
    add_vec(8'h0B, 8'h12, 8'h05, 8'h00, 8'hCB, 1'b0);
    add_vec(8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0);
`endif

    // Back-to-back: each op starts in the first idle cycle after the previous OUT_LO
    foreach (vecs[i]) begin
      do_op(vecs[i].m, vecs[i].q, vecs[i].r, vecs[i].hi, vecs[i].lo, vecs[i].noise,
            $sformatf("vec%0d", i));
    end

    // Abort mid-iteration: no product bytes may follow
    begin_mul = 1'b1;
    in_bus    = 8'h03;
    step();
    for (int c = 1; c <= 4; c++) begin
      begin_mul = 1'b0;
      in_bus    = (c == 1) ? 8'h05 : 8'h00;
      step();
    end
    rst = 1'b1;
    step();
    chk("abort fin", 32'(fin), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort out_bus", 32'(out_bus), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      step();
      chk($sformatf("post-abort fin c%0d", c), 32'(fin), 32'd0);
      chk($sformatf("post-abort busy c%0d", c), 32'(busy), 32'd0);
    end
    do_op(8'h03, 8'h05, 8'h00, 8'h00, 8'h0F, 1'b0, "after-abort");

    for (int n = 0; n < 40; n++) begin
      rm = W'($urandom);
      rq = W'($urandom);
      rr = W'($urandom);
      p  = model(rm, rq, rr);
      do_op(rm, rq, rr, p[2*W-1:W], p[W-1:0], (n % 5) == 0, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
